// File: rtl/sr_regfile_dump.sv
// sr_regfile_dump: walks FIRST_REG..LAST_REG over the regfile debug port
// and streams each word out on valid/ready. Optional: SR_REGFILE_DUMP_CSUM_EN.
module sr_regfile_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [4:0]  m_index,
    output logic        m_last,
    output logic        m_csum
);

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_data;
    logic [4:0]  r_index;
    logic [4:0]  r_addr;
    logic        w_hs;
    logic        w_at_last;

    assign w_hs      = ((r_state == S_SEND) || (r_state == S_CSUM)) && m_ready;
    assign w_at_last = (r_index == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    if (w_at_last) begin
`ifdef SR_REGFILE_DUMP_CSUM_EN
                        w_next = S_CSUM;
`else
                        w_next = S_DONE;
`endif
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD: w_next = S_SEND;
            S_CSUM: begin
                if (w_hs) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef SR_REGFILE_DUMP_CSUM_EN
    logic [31:0] r_sum;

    // Running sum of every data word accepted by the sink
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_sum <= '0;
        end else if (r_state == S_SEND && w_hs) begin
            r_sum <= r_sum + r_data;
        end
    end
`endif

    // Word capture, index tracking and debug-port address walk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_index <= '0;
            r_addr  <= FIRST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr <= FIRST;
                    if (start) begin
                        r_data  <= dbg_data;
                        r_index <= FIRST;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (!w_at_last) begin
                            r_addr <= 5'(r_index + 5'd1);
                        end else begin
                            r_addr <= FIRST;
`ifdef SR_REGFILE_DUMP_CSUM_EN
                            // checksum word reuses the data register
                            r_data <= r_sum + r_data;
`endif
                        end
                    end
                end
                S_LOAD: begin
                    r_data  <= dbg_data;
                    r_index <= r_addr;
                end
                default: begin
                    r_addr <= r_addr;
                end
            endcase
        end
    end

    // Moore output decode from registered state
    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        m_valid  = (r_state == S_SEND) || (r_state == S_CSUM);
        m_data   = r_data;
        m_index  = r_index;
        dbg_addr = r_addr;
`ifdef SR_REGFILE_DUMP_CSUM_EN
        m_last   = (r_state == S_CSUM);
        m_csum   = (r_state == S_CSUM);
`else
        m_last   = (r_state == S_SEND) && w_at_last;
        m_csum   = 1'b0;
`endif
    end

endmodule
